// File: rtl/encoder_16_4_seq.sv
// encoder_16_4_seq
//   Accepts a request vector (one-hot or multi-hot) over a valid/ready
//   handshake and serially emits the binary index of every set bit, lowest
//   index first, over a second valid/ready handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   enable     in   gates acceptance of new vectors only
//   vec_in     in   [WIDTH-1:0] request vector
//   in_valid   in   vec_in valid
//   in_ready   out  block can accept vec_in (IDLE and enable)
//   binary_out out  [OUT_W-1:0] index of current lowest set bit
//   out_valid  out  binary_out valid
//   out_ready  in   consumer accepts binary_out
//   out_last   out  current index is the final set bit of the vector
//   zero_pulse out  one-cycle flag: all-zero vector accepted and dropped
module encoder_16_4_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OUT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] vec_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] binary_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             zero_pulse
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [OUT_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic               zero_q, zero_d;

    logic               accept;
    logic               out_hs;

    assign in_ready = (state_q == IDLE) && enable;
    assign accept   = in_valid && in_ready;
    assign out_hs   = (state_q == DRAIN) && out_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (vec_in == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        pending_d = vec_in;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    // Clearing the lowest set bit retires the index just handed off.
                    pending_d = pending_q & (pending_q - WIDTH'(1));
                    if (last_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The index and last flag are precomputed from the next pending value so
    // that binary_out/out_last come straight from flops.
    always_comb begin
        idx_d = '0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (pending_d[i-1]) begin
                idx_d = OUT_W'(i - 1);
            end
        end
        last_d = (pending_d != '0) && ((pending_d & (pending_d - WIDTH'(1))) == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            zero_q    <= zero_d;
        end
    end

    assign out_valid  = (state_q == DRAIN);
    assign binary_out = idx_q;
    assign out_last   = last_q;
    assign zero_pulse = zero_q;

endmodule

// File: tb/tb_encoder_16_4_seq.sv
// tb_encoder_16_4_seq
//   Directed-vector bench for encoder_16_4_seq. Inputs are driven and
//   outputs sampled on the falling clock edge.
module tb_encoder_16_4_seq;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] vec_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  binary_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        zero_pulse;

    int unsigned n_checks;
    int unsigned n_errors;

    encoder_16_4_seq #(
        .WIDTH(16),
        .OUT_W(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .vec_in     (vec_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .binary_out (binary_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .zero_pulse (zero_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] idx, input logic last);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check({tag, ".idx"},  32'(binary_out), 32'(idx));
            check({tag, ".last"}, 32'(out_last),   32'(last));
        end
    endtask

    initial begin
        logic [3:0] exp_idx [4];
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        enable    = 1'b0;
        vec_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset then one-hot
        repeat (3) @(negedge clk);
        check("rst.out_valid",  32'(out_valid),  0);
        check("rst.in_ready",   32'(in_ready),   0);
        check("rst.binary_out", 32'(binary_out), 0);
        check("rst.out_last",   32'(out_last),   0);
        check("rst.zero_pulse", 32'(zero_pulse), 0);
        reset_n = 1'b1;
        enable  = 1'b1;
        #1;
        check("idle.in_ready", 32'(in_ready), 1);
        vec_in   = 16'h0020;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("onehot", 1'b1, 4'd5, 1'b1);
        check("onehot.in_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk_out("onehot.done", 1'b0, 4'd0, 1'b0);
        check("onehot.in_ready_back", 32'(in_ready), 1);

        // Multi-hot drain with in_valid ignored throughout
        exp_idx = '{4'd0, 4'd5, 4'd10, 4'd15};
        vec_in   = 16'h8421;
        in_valid = 1'b1;
        @(negedge clk);
        vec_in = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("multi[%0d]", i), 1'b1, exp_idx[i], i == 3);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk_out("multi.done", 1'b0, 4'd0, 1'b0);
        check("multi.in_ready", 32'(in_ready), 1);

        // Backpressure
        vec_in    = 16'h0006;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("stall[%0d]", i), 1'b1, 4'd1, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk_out("bp.first", 1'b1, 4'd1, 1'b0);
        @(negedge clk);
        chk_out("bp.second", 1'b1, 4'd2, 1'b1);
        @(negedge clk);
        chk_out("bp.done", 1'b0, 4'd0, 1'b0);

        // Zero vector
        vec_in   = 16'h0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("zero.pulse",    32'(zero_pulse), 1);
        check("zero.valid",    32'(out_valid),  0);
        check("zero.in_ready", 32'(in_ready),   1);
        @(negedge clk);
        check("zero.pulse_end", 32'(zero_pulse), 0);
        check("zero.valid2",    32'(out_valid),  0);

        // Single top bit
        vec_in   = 16'h8000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("top", 1'b1, 4'd15, 1'b1);
        @(negedge clk);
        chk_out("top.done", 1'b0, 4'd0, 1'b0);

        // Enable gating and full vector
        enable   = 1'b0;
        vec_in   = 16'h0001;
        in_valid = 1'b1;
        #1;
        check("dis.in_ready", 32'(in_ready), 0);
        @(negedge clk);
        check("dis.valid", 32'(out_valid), 0);
        enable = 1'b1;
        vec_in = 16'hFFFF;
        @(negedge clk);
        enable   = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_out($sformatf("full[%0d]", i), 1'b1, 4'(i), i == 15);
            @(negedge clk);
        end
        chk_out("full.done", 1'b0, 4'd0, 1'b0);
        check("full.in_ready_dis", 32'(in_ready), 0);
        enable = 1'b1;

        // Reset mid-drain
        vec_in   = 16'h00F0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("mid.first", 1'b1, 4'd4, 1'b0);
        @(negedge clk);
        chk_out("mid.second", 1'b1, 4'd5, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid.async_valid", 32'(out_valid),  0);
        check("mid.async_idx",   32'(binary_out), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid.post_valid",    32'(out_valid), 0);
        check("mid.post_in_ready", 32'(in_ready),  1);
        vec_in   = 16'h0001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("mid.next", 1'b1, 4'd0, 1'b1);
        @(negedge clk);
        chk_out("mid.next_done", 1'b0, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
